// File: rtl/hazard_scoreboard_if.sv
// Decode-to-hazard-controller bundle: decoded source/destination fields,
// EX/MEM pipeline control inputs, and the stall/bubble/flush decisions.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [2:0]       id_rs;
    logic             id_rs_used;
    logic [2:0]       id_rt;
    logic             id_rt_used;
    logic [2:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             ex_redirect;
    logic             mem_stall;
    logic             stall;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
               id_regwrite, id_memread, ex_redirect, mem_stall,
        input  stall, id_ex_bubble, if_id_flush, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd,
               id_regwrite, id_memread, ex_redirect, mem_stall,
        output stall, id_ex_bubble, if_id_flush, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard controller: tracks in-flight register writers in a
// three-slot shadow scoreboard (EX, MEM, WB) and decides stall, ID/EX bubble
// and IF/ID flush. Decisions are combinational from the slots and inputs.
module hazard_scoreboard #(
    parameter bit FORWARDING = 1'b0,
    parameter bit RF_BYPASS  = 1'b1,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic       rw;
        logic       ld;
    } slot_t;

    slot_t            ex_r;
    slot_t            mem_r;
    slot_t            wb_r;
    logic [CNT_W-1:0] cnt_r;

    logic hit_ex_s;
    logic hit_mem_s;
    logic hit_wb_s;
    logic raw_s;
    logic stall_s;
    logic accept_s;

    // A slot hits when it holds a live register writer targeting any source
    // actually read by the decoding instruction; R0 is not treated specially.
    function automatic logic slot_hit(
        input slot_t      s,
        input logic [2:0] rs,
        input logic       rs_used,
        input logic [2:0] rt,
        input logic       rt_used
    );
        return s.v & s.rw & ((rs_used & (s.rd == rs)) | (rt_used & (s.rd == rt)));
    endfunction

    // RAW detection against the scoreboard and the resulting pipeline controls.
    always_comb begin
        hit_ex_s  = slot_hit(ex_r,  bus.id_rs, bus.id_rs_used, bus.id_rt, bus.id_rt_used);
        hit_mem_s = slot_hit(mem_r, bus.id_rs, bus.id_rs_used, bus.id_rt, bus.id_rt_used);
        hit_wb_s  = slot_hit(wb_r,  bus.id_rs, bus.id_rs_used, bus.id_rt, bus.id_rt_used);
        if (FORWARDING) begin
            // With forwarding only a load still in EX cannot supply its value.
            raw_s = bus.id_valid & hit_ex_s & ex_r.ld;
        end else begin
            // Without a same-cycle RF write-through, WB is also a hazard.
            raw_s = bus.id_valid & (hit_ex_s | hit_mem_s | (!RF_BYPASS & hit_wb_s));
        end
        // A redirect kills the consumer, so it never stalls.
        stall_s  = raw_s & !bus.ex_redirect;
        accept_s = bus.id_valid & !raw_s & !bus.ex_redirect;
    end

    // Drive the interface outputs; bubble/flush are suppressed while frozen.
    always_comb begin
        bus.stall        = stall_s;
        bus.id_ex_bubble = (raw_s | bus.ex_redirect) & !bus.mem_stall;
        bus.if_id_flush  = bus.ex_redirect & !bus.mem_stall;
        bus.stall_count  = cnt_r;
    end

    // Advance the shadow pipeline and count stall cycles; hold when frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
            cnt_r <= '0;
        end else if (!bus.mem_stall) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (accept_s) begin
                ex_r <= {1'b1, bus.id_rd, bus.id_regwrite, bus.id_memread};
            end else begin
                ex_r <= '0;
            end
            if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench: four scoreboard configurations share one stimulus
// stream; each scenario checks the instance whose configuration it targets.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread;
    logic [2:0] id_rs, id_rt, id_rd;
    logic       ex_redirect, mem_stall;
    int checks = 0;
    int passed = 0;

    hazard_scoreboard_if #(.CNT_W(16)) b0 ();
    hazard_scoreboard_if #(.CNT_W(16)) b1 ();
    hazard_scoreboard_if #(.CNT_W(4))  b2 ();
    hazard_scoreboard_if #(.CNT_W(16)) b3 ();

    hazard_scoreboard #(.FORWARDING(1'b0), .RF_BYPASS(1'b1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    hazard_scoreboard #(.FORWARDING(1'b1), .RF_BYPASS(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    hazard_scoreboard #(.FORWARDING(1'b0), .RF_BYPASS(1'b1), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(b2));
    hazard_scoreboard #(.FORWARDING(1'b0), .RF_BYPASS(1'b0), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    assign b0.id_valid = id_valid; assign b0.id_rs = id_rs; assign b0.id_rs_used = id_rs_used;
    assign b0.id_rt = id_rt; assign b0.id_rt_used = id_rt_used; assign b0.id_rd = id_rd;
    assign b0.id_regwrite = id_regwrite; assign b0.id_memread = id_memread;
    assign b0.ex_redirect = ex_redirect; assign b0.mem_stall = mem_stall;
    assign b1.id_valid = id_valid; assign b1.id_rs = id_rs; assign b1.id_rs_used = id_rs_used;
    assign b1.id_rt = id_rt; assign b1.id_rt_used = id_rt_used; assign b1.id_rd = id_rd;
    assign b1.id_regwrite = id_regwrite; assign b1.id_memread = id_memread;
    assign b1.ex_redirect = ex_redirect; assign b1.mem_stall = mem_stall;
    assign b2.id_valid = id_valid; assign b2.id_rs = id_rs; assign b2.id_rs_used = id_rs_used;
    assign b2.id_rt = id_rt; assign b2.id_rt_used = id_rt_used; assign b2.id_rd = id_rd;
    assign b2.id_regwrite = id_regwrite; assign b2.id_memread = id_memread;
    assign b2.ex_redirect = ex_redirect; assign b2.mem_stall = mem_stall;
    assign b3.id_valid = id_valid; assign b3.id_rs = id_rs; assign b3.id_rs_used = id_rs_used;
    assign b3.id_rt = id_rt; assign b3.id_rt_used = id_rt_used; assign b3.id_rd = id_rd;
    assign b3.id_regwrite = id_regwrite; assign b3.id_memread = id_memread;
    assign b3.ex_redirect = ex_redirect; assign b3.mem_stall = mem_stall;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a decoded instruction, then let combinational outputs settle.
    task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu,
                          input logic [2:0] rd, input logic rw, input logic ld);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_regwrite = rw; id_memread = ld;
        #1;
    endtask

    task automatic do_reset();
        ex_redirect = 1'b0; mem_stall = 1'b0;
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ex_redirect = 1'b0; mem_stall = 1'b0;
        rst = 1'b1;
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (b0.stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", b0.stall); else passed++;
            checks++; if (b0.stall_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", b0.stall_count); else passed++;
        end
        rst = 1'b0;
        #1;
        checks++; if (b0.stall !== 1'b0) $display("FAIL reset_first_instr got=%b exp=0", b0.stall); else passed++;
        tick();
        // r3 writer is now in EX, so a reader of r3 must stall.
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
        checks++; if (b0.stall !== 1'b1) $display("FAIL reset_first_in_ex got=%b exp=1", b0.stall); else passed++;
    endtask

    task automatic test_raw_distance1();
        do_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);  // ADD r3
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);  // SUB r4 <- r3
        for (int i = 0; i < 2; i++) begin
            checks++; if (b0.stall !== 1'b1) $display("FAIL dist1_stall cyc=%0d got=%b exp=1", i, b0.stall); else passed++;
            checks++; if (b0.id_ex_bubble !== 1'b1) $display("FAIL dist1_bubble cyc=%0d got=%b exp=1", i, b0.id_ex_bubble); else passed++;
            tick();
        end
        checks++; if (b0.stall !== 1'b0) $display("FAIL dist1_release got=%b exp=0", b0.stall); else passed++;
        checks++; if (b3.stall !== 1'b1) $display("FAIL nobypass_wb_stall got=%b exp=1", b3.stall); else passed++;
        checks++; if (b0.stall_count !== 16'd2) $display("FAIL dist1_count got=%0d exp=2", b0.stall_count); else passed++;
        tick();
        checks++; if (b3.stall_count !== 16'd3) $display("FAIL nobypass_count got=%0d exp=3", b3.stall_count); else passed++;
        set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0);  // reader of r4
        checks++; if (b0.stall !== 1'b1) $display("FAIL dist1_sub_in_ex got=%b exp=1", b0.stall); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1);  // LD r5
        tick();
        set_id(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0);  // ADD r6 <- rt r5
        checks++; if (b1.stall !== 1'b1) $display("FAIL loaduse_stall got=%b exp=1", b1.stall); else passed++;
        tick();
        checks++; if (b1.stall !== 1'b0) $display("FAIL loaduse_one_cycle got=%b exp=0", b1.stall); else passed++;
        tick();
        checks++; if (b1.stall_count !== 16'd1) $display("FAIL loaduse_count got=%0d exp=1", b1.stall_count); else passed++;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);  // ADD r5 (not a load)
        tick();
        set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);  // reader of r5
        checks++; if (b1.stall !== 1'b0) $display("FAIL alu_fwd_nostall got=%b exp=0", b1.stall); else passed++;
        tick();
        checks++; if (b1.stall_count !== 16'd1) $display("FAIL alu_fwd_count got=%0d exp=1", b1.stall_count); else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);  // ADD r3
        tick();
        ex_redirect = 1'b1;
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);  // SUB r6 <- r3
        checks++; if (b0.stall !== 1'b0) $display("FAIL redir_stall got=%b exp=0", b0.stall); else passed++;
        checks++; if (b0.if_id_flush !== 1'b1) $display("FAIL redir_flush got=%b exp=1", b0.if_id_flush); else passed++;
        checks++; if (b0.id_ex_bubble !== 1'b1) $display("FAIL redir_bubble got=%b exp=1", b0.id_ex_bubble); else passed++;
        tick();
        ex_redirect = 1'b0;
        set_id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0);  // reader of r6
        checks++; if (b0.stall !== 1'b0) $display("FAIL redir_ex_empty got=%b exp=0", b0.stall); else passed++;
        checks++; if (b0.stall_count !== 16'd0) $display("FAIL redir_count got=%0d exp=0", b0.stall_count); else passed++;
    endtask

    task automatic test_mem_stall();
        do_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);  // ADD r3
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);  // reader of r3
        checks++; if (b0.stall !== 1'b1) $display("FAIL memst_pre got=%b exp=1", b0.stall); else passed++;
        tick();
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b0.id_ex_bubble !== 1'b0) $display("FAIL memst_bubble cyc=%0d got=%b exp=0", i, b0.id_ex_bubble); else passed++;
            checks++; if (b0.stall !== 1'b1) $display("FAIL memst_stall cyc=%0d got=%b exp=1", i, b0.stall); else passed++;
            tick();
            checks++; if (b0.stall_count !== 16'd1) $display("FAIL memst_count cyc=%0d got=%0d exp=1", i, b0.stall_count); else passed++;
        end
        mem_stall = 1'b0;
        #1;
        checks++; if (b0.id_ex_bubble !== 1'b1) $display("FAIL memst_resume_bubble got=%b exp=1", b0.id_ex_bubble); else passed++;
        tick();
        checks++; if (b0.stall !== 1'b0) $display("FAIL memst_done got=%b exp=0", b0.stall); else passed++;
        checks++; if (b0.stall_count !== 16'd2) $display("FAIL memst_final_count got=%0d exp=2", b0.stall_count); else passed++;
    endtask

    task automatic test_dual_source_r0();
        do_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);  // ADD r0
        tick();
        set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);  // reads r0 twice
        tick(); tick();
        checks++; if (b0.stall !== 1'b0) $display("FAIL dual_release got=%b exp=0", b0.stall); else passed++;
        checks++; if (b0.stall_count !== 16'd2) $display("FAIL dual_count got=%0d exp=2", b0.stall_count); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (b0.stall !== 1'b0) $display("FAIL midrst_stall got=%b exp=0", b0.stall); else passed++;
        checks++; if (b0.stall_count !== 16'd0) $display("FAIL midrst_count got=%0d exp=0", b0.stall_count); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        int nstall;
        nstall = 0;
        do_reset();
        // Each r1 <- r1 instruction enters, then the next one stalls 2 cycles.
        set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) begin
            if (b2.stall) nstall++;
            tick();
            if (i == 21) begin
                checks++; if (b2.stall_count !== 4'd14) $display("FAIL sat_mid got=%0d exp=14", b2.stall_count); else passed++;
            end
        end
        checks++; if (nstall !== 20) $display("FAIL sat_stall_cycles got=%0d exp=20", nstall); else passed++;
        checks++; if (b2.stall_count !== 4'd15) $display("FAIL sat_count got=%0d exp=15", b2.stall_count); else passed++;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (b2.stall_count !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", b2.stall_count); else passed++;
    endtask

    // Run every scenario in sequence and report.
    initial begin
        rst = 1'b1;
        ex_redirect = 1'b0; mem_stall = 1'b0;
        id_valid = 1'b0; id_rs = 3'd0; id_rs_used = 1'b0; id_rt = 3'd0; id_rt_used = 1'b0;
        id_rd = 3'd0; id_regwrite = 1'b0; id_memread = 1'b0;
        test_reset();
        test_raw_distance1();
        test_load_use();
        test_redirect();
        test_mem_stall();
        test_dual_source_r0();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
